// File: rtl/timer_counter_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_core_if
//  Description : Register-strobe, tick and status bundle between the register
//                decode / prescaler control (master) and the timer counter
//                core (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_counter_core_if #(
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32
);
  logic              cnt_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_cnt_lo;
  logic              wr_cnt_hi;
  logic              wr_cmp_lo;
  logic              wr_cmp_hi;
  logic              int_en;
  logic              int_clr;
  logic              dbg_mode;
  logic              halt_req;
  logic [CNT_W-1:0]  cnt_out;
  logic [CNT_W-1:0]  cmp_out;
  logic              int_st;
  logic              tim_int;
  logic              halt_ack;

  modport master (
    output cnt_en, wr_data, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi,
           int_en, int_clr, dbg_mode, halt_req,
    input  cnt_out, cmp_out, int_st, tim_int, halt_ack
  );

  modport slave (
    input  cnt_en, wr_data, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi,
           int_en, int_clr, dbg_mode, halt_req,
    output cnt_out, cmp_out, int_st, tim_int, halt_ack
  );
endinterface
`default_nettype wire

// File: rtl/timer_counter_core.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_core
//  Description : 64-bit (CNT_W) timer count advanced by prescaler ticks, with
//                software-loadable count/compare halves, a sticky level-
//                sensitive compare-match status, interrupt line and a
//                registered debug-halt acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_counter_core #(
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32
) (
  input  wire                  sys_clk,
  input  wire                  sys_rst,
  timer_counter_core_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp;
  logic             int_st;
  logic             halt_ack;
  logic             match;

  // Equality on registered values; drives the status set one edge later.
  assign match = (cnt == cmp);

  // Count register: software load beats the tick (tick is dropped), else
  // full-width increment wrapping silently modulo 2^CNT_W.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (bus.wr_cnt_lo || bus.wr_cnt_hi) begin
      if (bus.wr_cnt_lo) cnt[31:0]       <= bus.wr_data[31:0];
      if (bus.wr_cnt_hi) cnt[CNT_W-1:32] <= bus.wr_data[CNT_W-33:0];
    end else if (bus.cnt_en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Compare register: each half loads independently from its own strobe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cmp <= '1;
    end else begin
      if (bus.wr_cmp_lo) cmp[31:0]       <= bus.wr_data[31:0];
      if (bus.wr_cmp_hi) cmp[CNT_W-1:32] <= bus.wr_data[CNT_W-33:0];
    end
  end

  // Sticky status: a match re-sets every cycle and wins over a same-cycle clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      int_st <= 1'b0;
    end else if (match) begin
      int_st <= 1'b1;
    end else if (bus.int_clr) begin
      int_st <= 1'b0;
    end
  end

  // Halt acknowledge follows the qualified request with one cycle of latency;
  // the counter itself is frozen by the prescaler withholding cnt_en.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      halt_ack <= 1'b0;
    end else begin
      halt_ack <= bus.halt_req & bus.dbg_mode;
    end
  end

  assign bus.cnt_out  = cnt;
  assign bus.cmp_out  = cmp;
  assign bus.int_st   = int_st;
  assign bus.tim_int  = bus.int_en & int_st;
  assign bus.halt_ack = halt_ack;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter_core
//  Description : Directed-vector self-checking bench for timer_counter_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_counter_core;

  localparam int CNT_W  = 64;
  localparam int DATA_W = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  timer_counter_core_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  timer_counter_core #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // One comparison: count it, report a miscompare.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr_cnt(input logic lo, input logic hi, input logic [31:0] d);
    bus.wr_cnt_lo = lo; bus.wr_cnt_hi = hi; bus.wr_data = d;
    step();
    bus.wr_cnt_lo = 1'b0; bus.wr_cnt_hi = 1'b0;
  endtask

  task automatic wr_cmp(input logic lo, input logic hi, input logic [31:0] d);
    bus.wr_cmp_lo = lo; bus.wr_cmp_hi = hi; bus.wr_data = d;
    step();
    bus.wr_cmp_lo = 1'b0; bus.wr_cmp_hi = 1'b0;
  endtask

  initial begin
    bus.cnt_en = 0; bus.wr_data = '0; bus.wr_cnt_lo = 0; bus.wr_cnt_hi = 0;
    bus.wr_cmp_lo = 0; bus.wr_cmp_hi = 0; bus.int_en = 0; bus.int_clr = 0;
    bus.dbg_mode = 0; bus.halt_req = 0;

    // Reset values
    #12;
    chk("rst_cnt",    bus.cnt_out, 64'h0);
    chk("rst_cmp",    bus.cmp_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_int_st", {63'h0, bus.int_st}, 64'h0);
    chk("rst_tim_int",{63'h0, bus.tim_int}, 64'h0);
    chk("rst_halt",   {63'h0, bus.halt_ack}, 64'h0);
    step();
    sys_rst = 1'b0;

    // Five ticks
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.cnt_en = 1'b0;
    step();
    chk("five_ticks", bus.cnt_out, 64'h5);
    chk("five_int_st", {63'h0, bus.int_st}, 64'h0);

    // Carry from low into high half
    wr_cnt(1'b1, 1'b0, 32'hFFFF_FFFF);
    wr_cnt(1'b0, 1'b1, 32'h0);
    chk("load_lo_hi", bus.cnt_out, 64'h0000_0000_FFFF_FFFF);
    bus.cnt_en = 1'b1; step(); bus.cnt_en = 1'b0;
    chk("carry_hi", bus.cnt_out, 64'h0000_0001_0000_0000);

    // Wrap through all-ones with a distant compare
    wr_cnt(1'b1, 1'b0, 32'hFFFF_FFFE);
    wr_cnt(1'b0, 1'b1, 32'hFFFF_FFFF);
    wr_cmp(1'b1, 1'b0, 32'h10);
    wr_cmp(1'b0, 1'b1, 32'h0);
    chk("cmp_load", bus.cmp_out, 64'h10);
    chk("cmp_no_cnt_effect", bus.cnt_out, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.cnt_en = 1'b1;
    step();
    chk("all_ones", bus.cnt_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap1_int_st", {63'h0, bus.int_st}, 64'h0);
    step();
    bus.cnt_en = 1'b0;
    chk("wrap_zero", bus.cnt_out, 64'h0);
    step();
    chk("wrap2_int_st", {63'h0, bus.int_st}, 64'h0);

    // Same-cycle lo+hi load uses the same data word
    wr_cnt(1'b1, 1'b1, 32'h0000_005A);
    chk("load_both", bus.cnt_out, 64'h0000_005A_0000_005A);

    // Compare match, latency and clear priority
    wr_cnt(1'b1, 1'b1, 32'h0000_000E);
    wr_cnt(1'b0, 1'b1, 32'h0);
    bus.int_en = 1'b1;
    bus.cnt_en = 1'b1;
    step();
    chk("cnt_0f", bus.cnt_out, 64'hF);
    step();
    bus.cnt_en = 1'b0;
    chk("cnt_10", bus.cnt_out, 64'h10);
    chk("match_lat_int_st", {63'h0, bus.int_st}, 64'h0);
    step();
    chk("match_int_st", {63'h0, bus.int_st}, 64'h1);
    chk("match_tim_int", {63'h0, bus.tim_int}, 64'h1);
    bus.int_en = 1'b0; #1;
    chk("int_en_off_tim_int", {63'h0, bus.tim_int}, 64'h0);
    chk("int_en_off_int_st", {63'h0, bus.int_st}, 64'h1);
    bus.int_en = 1'b1;
    bus.int_clr = 1'b1;
    step();
    bus.int_clr = 1'b0;
    chk("clr_vs_match", {63'h0, bus.int_st}, 64'h1);
    bus.cnt_en = 1'b1;
    step();
    bus.cnt_en = 1'b0;
    chk("cnt_11", bus.cnt_out, 64'h11);
    bus.int_clr = 1'b1;
    step();
    bus.int_clr = 1'b0;
    chk("clr_int_st", {63'h0, bus.int_st}, 64'h0);
    chk("clr_tim_int", {63'h0, bus.tim_int}, 64'h0);

    // Load beats a same-cycle tick
    bus.cnt_en = 1'b1;
    wr_cnt(1'b1, 1'b0, 32'h100);
    bus.cnt_en = 1'b0;
    chk("load_over_tick", bus.cnt_out, 64'h100);

    // Halt request without debug mode is ignored
    bus.halt_req = 1'b1;
    step();
    chk("halt_no_dbg", {63'h0, bus.halt_ack}, 64'h0);
    bus.halt_req = 1'b0;
    step();

    // Three-cycle halt pulse in debug mode
    bus.dbg_mode = 1'b1;
    bus.halt_req = 1'b1;
    chk("halt_pre", {63'h0, bus.halt_ack}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_ack_hi", {63'h0, bus.halt_ack}, 64'h1);
    end
    bus.halt_req = 1'b0;
    step();
    chk("halt_ack_lo", {63'h0, bus.halt_ack}, 64'h0);
    chk("halt_cnt_hold", bus.cnt_out, 64'h100);

    // Tick while acknowledged still counts
    bus.halt_req = 1'b1;
    step();
    bus.cnt_en = 1'b1;
    step();
    bus.cnt_en = 1'b0;
    chk("tick_in_halt", bus.cnt_out, 64'h101);
    chk("halt_ack_again", {63'h0, bus.halt_ack}, 64'h1);

    // Asynchronous reset mid-pulse
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_halt", {63'h0, bus.halt_ack}, 64'h0);
    chk("async_cnt", bus.cnt_out, 64'h0);
    chk("async_cmp", bus.cmp_out, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.halt_req = 1'b0;
    bus.dbg_mode = 1'b0;
    step();
    sys_rst = 1'b0;
    bus.cnt_en = 1'b1;
    step();
    bus.cnt_en = 1'b0;
    chk("first_tick_after_rst", bus.cnt_out, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_counter_core.md
Name: timer_counter_core

Overview:
- Consumer end of the prescaler tick interface: takes the single-cycle `cnt_en` ticks produced by the timer's counter-control block and advances a 64-bit timer count.
- Holds the software-loadable count and compare registers.
- Raises a sticky compare-match interrupt.
- Returns the debug-halt acknowledge that closes the `halt_req` loop.
- Sits between the register-interface decode and the prescaler control.

Parameters:
- CNT_W, 64, counter and compare width; legal range 33..64; the high half is bits [CNT_W-1:32].
- DATA_W, 32, register write-data width; fixed at 32.

Ports:
- sys_clk  input  1  system clock; all state on rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- cnt_en  input  1  count tick from prescaler control; one increment per high cycle.
- wr_data  input  DATA_W  write data for the load strobes.
- wr_cnt_lo  input  1  load count[31:0] from wr_data.
- wr_cnt_hi  input  1  load count[CNT_W-1:32] from wr_data[CNT_W-33:0].
- wr_cmp_lo  input  1  load compare[31:0].
- wr_cmp_hi  input  1  load compare[CNT_W-1:32].
- int_en  input  1  interrupt output enable.
- int_clr  input  1  write-1-to-clear for int_st.
- dbg_mode  input  1  debug mode active.
- halt_req  input  1  halt request, shared with prescaler control.
- cnt_out  output  CNT_W  current count.
- cmp_out  output  CNT_W  current compare value.
- int_st  output  1  sticky interrupt status.
- tim_int  output  1  interrupt line.
- halt_ack  output  1  halt acknowledge.

Behaviour:
- Reset (async, sys_rst=1, takes effect immediately regardless of clock):
  - cnt_out = 0.
  - cmp_out = all ones.
  - int_st = 0.
  - halt_ack = 0.
  - tim_int = 0.
- Count register, per cycle, in priority order:
  - Any wr_cnt_lo/wr_cnt_hi asserted: the addressed half(es) load from wr_data; the unaddressed half holds. The tick is dropped that cycle (no increment of either half).
  - Else cnt_en=1: cnt_out <= cnt_out + 1, modulo 2^CNT_W.
  - Else hold.
- Wrap and lo/hi carry:
  - All ones + tick → 0; no wrap flag, no stall.
  - Carry from bit 31 into the high half is the same-cycle full-width increment; no split pipeline.
  - wr_cnt_lo and wr_cnt_hi in the same cycle load both halves from the same wr_data.
- Compare register:
  - wr_cmp_lo/wr_cmp_hi load the addressed half next edge; the other half holds.
  - Compare writes never affect the count.
- Match detection:
  - match = (cnt_out == cmp_out), evaluated on registered values, combinational.
  - match=1 → int_st <= 1 at next edge. Latency: the count reaches cmp on edge N; int_st=1 after edge N+1.
  - Level sensitive: int_st re-sets every cycle the count stays equal to compare, including while halted or while cnt_en=0.
- int_st clear:
  - int_clr=1 with match=0 → int_st <= 0.
  - int_clr=1 with match=1 in the same cycle → set wins, int_st stays 1.
- tim_int:
  - Combinational: int_en & int_st.
  - int_en has no effect on int_st (status sets even when disabled).
- halt_ack:
  - Registered: halt_ack <= halt_req & dbg_mode; one-cycle latency on assert and deassert.
  - Counter does not self-gate on halt: the freeze comes from prescaler control suppressing cnt_en.
  - A cnt_en seen while halt_ack=1 still increments (defensive, documented).
- Reset mid-operation: all state returns to reset values asynchronously; the first tick after release counts 0→1.
- No handshakes on write strobes: each strobe is single-cycle and level-qualified; a strobe held N cycles reloads N times.

Test Plan:
- Reset, then 5 cnt_en pulses, no writes → cnt_out=5; int_st=0 (cmp=FFFF_FFFF_FFFF_FFFF).
- wr_cnt_lo=FFFF_FFFF, wr_cnt_hi=0, then one tick → cnt_out=0x0000_0001_0000_0000 (carry into high half).
- cnt=0xFFFF_FFFF_FFFF_FFFE, cmp=0x10, 2 ticks → cnt passes all-ones and wraps to 0; int_st stays 0 throughout.
- cmp=0x10, count from 0x0E with int_en=1 → int_st and tim_int rise the cycle after cnt_out=0x10. int_clr while cnt still 0x10 → int_st stays 1. One more tick then int_clr → int_st=0.
- wr_cnt_lo=0x100 and cnt_en=1 in the same cycle → cnt_out=0x100, not 0x101.
- dbg_mode=1, pulse halt_req high for 3 cycles with cnt_en held 0 → halt_ack high 3 cycles delayed by 1, cnt_out unchanged. Assert sys_rst mid-pulse → halt_ack=0 immediately.
